// File: rtl/pipe_stage_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_if
// Handshake bundle between two adjacent pipeline stages, as seen by one
// pipe_stage_reg instance.
//   in_valid/in_ready/in_data/in_ctrl      upstream side (producer -> stage)
//   out_valid/out_ready/out_data/out_ctrl  downstream side (stage -> consumer)
// Modports:
//   master : the surrounding logic (drives upstream payload and out_ready)
//   slave  : the stage register itself
// -----------------------------------------------------------------------------
interface pipe_stage_reg_if #(
  parameter int DATA_W = 97,
  parameter int CTRL_W = 7
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Generic pipeline stage register carrying one data bus and one control bus
// with a valid/ready handshake, synchronous flush, control zeroing on every
// invalidated entry and a saturating stall counter.
//
// Build option: define PIPE_STAGE_SKID_EN to add a second (skid) entry and a
// registered in_ready. Without it the stage holds a single entry and in_ready
// is combinational (!out_valid || out_ready).
//
// Ports:
//   clk        clock, all state on the rising edge
//   reset      asynchronous, active-high reset
//   bus        pipe_stage_reg_if.slave (upstream + downstream handshake)
//   flush      synchronous kill of every held entry (wins over accept/release)
//   occupancy  number of entries held (0..2, 0..1 without the skid entry)
//   stall_cnt  cycles with out_valid && !out_ready, saturating, reset-only clear
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int DATA_W = 97,
  parameter int CTRL_W = 7,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  pipe_stage_reg_if.slave  bus,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  // State encoding equals the entry count, so occupancy is the state itself.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] FULL  = 2'd1;
  localparam logic [1:0] SKID  = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
`endif

  logic accept;
  logic retire;

  assign accept = bus.in_valid && bus.in_ready;
  assign retire = bus.out_valid && bus.out_ready;

`ifdef PIPE_STAGE_SKID_EN
  // Derived only from the state register: no path from out_ready to in_ready.
  assign bus.in_ready = !reset && (state != SKID);
`else
  assign bus.in_ready = !reset && ((state == EMPTY) || bus.out_ready);
`endif

  assign bus.out_valid = (state != EMPTY);
  assign bus.out_data  = main_data;
  // main_ctrl is zeroed whenever the head is invalidated, so it is already
  // all-zero whenever out_valid is low.
  assign bus.out_ctrl  = main_ctrl;
  assign occupancy     = state;

  // NOTE: the payload registers are reset too, because out_data must read 0
  // after reset; they are plain flops, not a RAM, so this is cheap and legal.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_data <= '0;
      skid_ctrl <= '0;
`endif
    end else if (flush) begin
      // Data keeps its last value; only control is cleared so a bubble can
      // never trigger RegWrite/MemWrite downstream.
      state     <= EMPTY;
      main_ctrl <= '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_ctrl <= '0;
`endif
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state     <= FULL;
            main_data <= bus.in_data;
            main_ctrl <= bus.in_ctrl;
          end
        end
        FULL: begin
          if (accept && retire) begin
            main_data <= bus.in_data;
            main_ctrl <= bus.in_ctrl;
          end else if (accept) begin
`ifdef PIPE_STAGE_SKID_EN
            // Head is stalled: park the newcomer behind it.
            state     <= SKID;
            skid_data <= bus.in_data;
            skid_ctrl <= bus.in_ctrl;
`endif
          end else if (retire) begin
            state     <= EMPTY;
            main_ctrl <= '0;
          end
        end
        SKID: begin
`ifdef PIPE_STAGE_SKID_EN
          if (retire) begin
            state     <= FULL;
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
            skid_ctrl <= '0;
          end
`else
          state <= EMPTY;
`endif
        end
        default: begin
          state     <= EMPTY;
          main_ctrl <= '0;
        end
      endcase
    end
  end

  // Counts every stalled head cycle, including flush cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (bus.out_valid && !bus.out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register, the next generation of the fixed-field EX/MEM register: it carries one generic data bus and one control bus between any two adjacent pipeline stages. It adds a valid/ready handshake, stall and flush with control zeroing, an optional two-entry skid buffer, and a saturating stall counter. It instantiates between IF/ID, ID/EX, EX/MEM and MEM/WB.

## Interface
- DATA_W, 97, data payload width (EX/MEM: PC_next 32 + ALU result 32 + read data 2 32 + zero 1)
- CTRL_W, 7, control field width (Branch, MemRead, MemToReg, MemWrite, RegWrite, Jump, Zero)
- CNT_W, 16, stall counter width
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept this cycle
- in_data  in  DATA_W  upstream payload
- in_ctrl  in  CTRL_W  upstream control bits
- flush  in  1  synchronous kill of all held entries
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head
- out_data  out  DATA_W  head payload
- out_ctrl  out  CTRL_W  head control; all-zero whenever out_valid=0
- occupancy  out  2  entries held (0..2)
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Accept: in_valid && in_ready. Release: out_valid && out_ready.
- States: EMPTY (occ 0), FULL (occ 1, main register), SKID (occ 2, main + skid register).
- EMPTY: accept -> FULL.
- FULL: accept & release -> FULL with new entry; accept only -> SKID (entry stored in skid); release only -> EMPTY; neither -> hold.
- SKID: in_ready=0; release -> FULL, skid entry moves to main; else hold.
- flush=1: next state EMPTY, occupancy 0, out_ctrl cleared; overrides simultaneous accept (flushed-cycle input is dropped) and release.
- Invalidated entries: ctrl bits cleared to 0 so downstream RegWrite/MemWrite can never fire on a bubble; data bits retain last value.
- stall_cnt: increments each cycle out_valid && !out_ready, stops at all-ones, unaffected by flush, cleared only by reset.
- Reset: state EMPTY, out_valid=0, in_ready=0 during reset then 1, out_data=0, out_ctrl=0, occupancy=0, stall_cnt=0; reset mid-transfer discards all entries.

## Timing
- Latency in->out: 1 cycle (accept on edge N, out_valid on edge N, visible cycle N+1).
- Throughput: 1 entry/cycle when out_ready held high.
- Skid mode: in_ready is a register output (no combinational path out_ready->in_ready); deasserts the cycle after entering SKID, reasserts the cycle after leaving it.
- Non-skid mode: in_ready = !out_valid || out_ready, combinational.
- flush acts on the same edge it is sampled; out_valid=0 the following cycle.
- Data order strictly FIFO; no entry dropped except by flush/reset.

## Configuration
- PIPE_STAGE_SKID_EN defined: two-entry skid buffer, registered in_ready, occupancy 0..2, states as above.
- Undefined: single register only, no SKID state, combinational in_ready, occupancy never exceeds 1; all other behaviour identical.

## Test plan
- Reset asserted mid-stream with occupancy 2 -> next cycle out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cnt=0.
- Stream 0x1..0x8 with in_valid, out_ready both high -> out_data 0x1..0x8 in order, one per cycle, 1-cycle latency, stall_cnt=0.
- Skid build: feed 0xA, 0xB with out_ready=0 -> occupancy 2, in_ready=0, stall_cnt counts; raise out_ready -> 0xA then 0xB, in_ready returns 1.
- flush with in_valid=1, in_ctrl=7'h7F, occupancy 2 -> next cycle out_valid=0, out_ctrl=0, occupancy=0; the flushed input never appears.
- Hold out_ready=0 with CNT_W=4 for 20 cycles -> stall_cnt saturates at 15 and stays.
- Build without PIPE_STAGE_SKID_EN: out_ready=0 and in_valid=1 -> in_ready=0 same cycle, occupancy stays 1.
